// File: rtl/line_sensor_encoder.sv
// Line-follower encoder: samples an 8-bit reflectance array, debounces the class, and drives a steering command.
// Optional LINE_SEARCH_EN: on line loss, keep steering toward the last turn for SEARCH_SAMPLES ticks before stopping.
module line_sensor_encoder #(
   parameter int unsigned SAMPLE_DIV       = 5000,
   parameter int unsigned DEBOUNCE_SAMPLES = 4,
   parameter int unsigned SEARCH_SAMPLES   = 64
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       enable,
   input  logic [7:0] sensor,
   output logic [1:0] direction_command,
   output logic       cmd_valid,
   output logic       line_lost
);

   localparam int unsigned DIV_W  = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
   localparam int unsigned RUN_W  = 4;
   localparam int unsigned SRCH_W = 8;

   localparam logic [2:0] CLS_STRAIGHT = 3'd0;
   localparam logic [2:0] CLS_RIGHT    = 3'd1;
   localparam logic [2:0] CLS_LEFT     = 3'd2;
   localparam logic [2:0] CLS_STOP     = 3'd3;
   localparam logic [2:0] CLS_LOST     = 3'd4;

   localparam logic [1:0] CMD_STOP = 2'd3;

   typedef enum logic [1:0] {
      ST_TRACK   = 2'd0,
      ST_STOPPED = 2'd1
`ifdef LINE_SEARCH_EN
      , ST_SEARCH = 2'd2
`endif
   } state_t;

   if (SAMPLE_DIV < 2) begin : g_bad_div
      $error("SAMPLE_DIV must be >= 2");
   end
   if (DEBOUNCE_SAMPLES < 1 || DEBOUNCE_SAMPLES > 15) begin : g_bad_deb
      $error("DEBOUNCE_SAMPLES must be 1..15");
   end
   if (SEARCH_SAMPLES < 1 || SEARCH_SAMPLES > 255) begin : g_bad_srch
      $error("SEARCH_SAMPLES must be 1..255");
   end

   logic [DIV_W-1:0] r_div_cnt;
   logic             w_tick;
   logic [3:0]       w_pop;
   logic [1:0]       w_left;
   logic [1:0]       w_right;
   logic [2:0]       w_class;
   logic [2:0]       r_prev_class;
   logic [RUN_W-1:0] r_run;
   logic [RUN_W-1:0] w_run_next;
   logic             w_same;
   logic             w_commit;
   state_t           r_state;
   logic [1:0]       r_dir;
   logic             r_cmd_valid;
   logic             r_line_lost;
`ifdef LINE_SEARCH_EN
   logic [1:0]        r_last_turn;
   logic [1:0]        w_turn_code;
   logic [SRCH_W-1:0] r_search_cnt;
`endif

   // Free-running sample divider
   assign w_tick = (r_div_cnt == DIV_W'(SAMPLE_DIV - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    r_div_cnt <= '0;
      else if (w_tick) r_div_cnt <= '0;
      else             r_div_cnt <= r_div_cnt + DIV_W'(1);
   end

   // Classification; center bits 4:3 only count toward the STOP popcount
   always_comb begin
      w_pop = '0;
      for (int i = 0; i < 8; i++) w_pop = w_pop + 4'(sensor[i]);
      w_left  = 2'(sensor[7]) + 2'(sensor[6]) + 2'(sensor[5]);
      w_right = 2'(sensor[2]) + 2'(sensor[1]) + 2'(sensor[0]);
      w_class = CLS_STRAIGHT;
      if (sensor == 8'd0)          w_class = CLS_LOST;
      else if (w_pop >= 4'd6)      w_class = CLS_STOP;
      else if (w_right > w_left)   w_class = CLS_RIGHT;
      else if (w_left > w_right)   w_class = CLS_LEFT;
   end

   // Commit only on the tick the run first reaches its target, not while it stays saturated
   assign w_same     = (w_class == r_prev_class);
   assign w_run_next = !w_same ? RUN_W'(1) :
                       (r_run == RUN_W'(DEBOUNCE_SAMPLES)) ? r_run : r_run + RUN_W'(1);
   assign w_commit   = w_tick && enable && (w_run_next == RUN_W'(DEBOUNCE_SAMPLES)) &&
                       !(w_same && (r_run == RUN_W'(DEBOUNCE_SAMPLES)));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_prev_class <= CLS_LOST;
         r_run        <= '0;
      end else begin
         if (w_tick) r_prev_class <= w_class;
         if (!enable)     r_run <= '0;
         else if (w_tick) r_run <= w_run_next;
      end
   end

`ifdef LINE_SEARCH_EN
   assign w_turn_code = (r_last_turn == 2'd0) ? CMD_STOP : r_last_turn;
`endif

   // Control FSM with registered command outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_STOPPED;
         r_dir       <= CMD_STOP;
         r_cmd_valid <= 1'b0;
         r_line_lost <= 1'b0;
`ifdef LINE_SEARCH_EN
         r_last_turn  <= 2'd0;
         r_search_cnt <= '0;
`endif
      end else begin
         r_cmd_valid <= 1'b0;
         if (!enable) begin
            r_state     <= ST_STOPPED;
            r_dir       <= CMD_STOP;
            r_cmd_valid <= (r_dir != CMD_STOP);
            r_line_lost <= 1'b0;
`ifdef LINE_SEARCH_EN
            r_search_cnt <= '0;
`endif
         end else if (w_commit && (w_class != CLS_LOST)) begin
            r_state     <= ST_TRACK;
            r_dir       <= w_class[1:0];
            r_cmd_valid <= (r_dir != w_class[1:0]);
            r_line_lost <= 1'b0;
`ifdef LINE_SEARCH_EN
            r_search_cnt <= '0;
            r_last_turn  <= (w_class == CLS_RIGHT || w_class == CLS_LEFT) ? w_class[1:0] : 2'd0;
`endif
         end else if (w_commit && (r_state == ST_TRACK)) begin
`ifdef LINE_SEARCH_EN
            r_state      <= ST_SEARCH;
            r_search_cnt <= SRCH_W'(SEARCH_SAMPLES);
            r_dir        <= w_turn_code;
            r_cmd_valid  <= (r_dir != w_turn_code);
`else
            r_state      <= ST_STOPPED;
            r_dir        <= CMD_STOP;
            r_cmd_valid  <= (r_dir != CMD_STOP);
`endif
            r_line_lost  <= 1'b1;
`ifdef LINE_SEARCH_EN
         end else if (w_tick && (r_state == ST_SEARCH)) begin
            if (r_search_cnt <= SRCH_W'(1)) begin
               r_state      <= ST_STOPPED;
               r_search_cnt <= '0;
               r_dir        <= CMD_STOP;
               r_cmd_valid  <= (r_dir != CMD_STOP);
            end else begin
               r_search_cnt <= r_search_cnt - SRCH_W'(1);
            end
`endif
         end
      end
   end

   assign direction_command = r_dir;
   assign cmd_valid         = r_cmd_valid;
   assign line_lost         = r_line_lost;

endmodule

// File: tb/tb_line_sensor_encoder.sv
// Scoreboard bench for line_sensor_encoder (SAMPLE_DIV=10, DEBOUNCE_SAMPLES=4, SEARCH_SAMPLES=3).
// Expectations follow LINE_SEARCH_EN when the bench is compiled with it.
module tb_line_sensor_encoder;

   localparam int unsigned DIV = 10;

   typedef struct packed {
      logic [1:0] dir;
      logic       lost;
   } exp_t;

   logic       clk;
   logic       reset_n;
   logic       enable;
   logic [7:0] sensor;
   logic [1:0] direction_command;
   logic       cmd_valid;
   logic       line_lost;

   exp_t q_exp[$];
   int   n_vec = 0;
   int   n_err = 0;

   line_sensor_encoder #(
      .SAMPLE_DIV      (DIV),
      .DEBOUNCE_SAMPLES(4),
      .SEARCH_SAMPLES  (3)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .enable           (enable),
      .sensor           (sensor),
      .direction_command(direction_command),
      .cmd_valid        (cmd_valid),
      .line_lost        (line_lost)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input logic [1:0] dir, input logic lost);
      exp_t e;
      e.dir  = dir;
      e.lost = lost;
      q_exp.push_back(e);
   endtask

   // Advance n sample ticks from a point just after a tick edge
   task automatic ticks(input int n);
      repeat (n * DIV) @(posedge clk);
      #1;
   endtask

   // Monitor: every cmd_valid pulse consumes one scoreboard entry
   always @(negedge clk) begin
      if (reset_n && cmd_valid) begin
         if (q_exp.size() == 0) begin
            check("unexpected_cmd_valid", int'(direction_command), -1);
         end else begin
            exp_t e;
            e = q_exp.pop_front();
            check("sb_dir", int'(direction_command), int'(e.dir));
            check("sb_lost", int'(line_lost), int'(e.lost));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      clk = 1'b0;
      reset_n = 1'b0;
      enable = 1'b1;
      sensor = 8'd0;
      repeat (3) @(negedge clk);
      check("rst_dir", int'(direction_command), 3);
      check("rst_valid", int'(cmd_valid), 0);
      check("rst_lost", int'(line_lost), 0);

      // Straight held: commit on 4th tick (edge 40 after release)
      sensor = 8'b00011000;
      push(2'd0, 1'b0);
      reset_n = 1'b1;
      repeat (4 * DIV - 1) @(posedge clk);
      #1;
      check("straight_early", int'(direction_command), 3);
      @(posedge clk);
      #1;
      check("straight_commit", int'(direction_command), 0);
      check("straight_pulse", int'(cmd_valid), 1);

      // Three right ticks then four left ticks
      sensor = 8'b00001100;
      ticks(3);
      check("right_suppressed", int'(direction_command), 0);
      sensor = 8'b00110000;
      push(2'd2, 1'b0);
      ticks(3);
      check("left_early", int'(direction_command), 0);
      ticks(1);
      check("left_commit", int'(direction_command), 2);

      // Right commit then line loss
      sensor = 8'b00000110;
      push(2'd1, 1'b0);
      ticks(4);
      check("right_commit", int'(direction_command), 1);
      sensor = 8'd0;
`ifdef LINE_SEARCH_EN
      ticks(4);
      check("search_dir", int'(direction_command), 1);
      check("search_lost", int'(line_lost), 1);
      push(2'd3, 1'b1);
      ticks(2);
      check("search_hold", int'(direction_command), 1);
      ticks(1);
      check("search_timeout_dir", int'(direction_command), 3);
      check("search_timeout_lost", int'(line_lost), 1);
`else
      push(2'd3, 1'b1);
      ticks(3);
      check("lost_early", int'(direction_command), 1);
      ticks(1);
      check("lost_dir", int'(direction_command), 3);
      check("lost_flag", int'(line_lost), 1);
      ticks(3);
      check("lost_hold_dir", int'(direction_command), 3);
      check("lost_hold_flag", int'(line_lost), 1);
`endif
      sensor = 8'b00011000;
      push(2'd0, 1'b0);
      ticks(4);
      check("recover_dir", int'(direction_command), 0);
      check("recover_lost", int'(line_lost), 0);

      // Six bits lit -> STOP
      sensor = 8'b11111100;
      push(2'd3, 1'b0);
      ticks(4);
      check("stop_dir", int'(direction_command), 3);
      check("stop_lost", int'(line_lost), 0);

      // enable drops in the cycle of a would-be straight commit
      sensor = 8'b00011000;
      ticks(3);
      repeat (DIV - 1) @(posedge clk);
      #1;
      enable = 1'b0;
      @(posedge clk);
      #1;
      check("disable_dir", int'(direction_command), 3);
      check("disable_lost", int'(line_lost), 0);
      repeat (DIV) @(posedge clk);
      #1;
      enable = 1'b1;
      push(2'd0, 1'b0);
      ticks(3);
      check("reenable_early", int'(direction_command), 3);
      ticks(1);
      check("reenable_commit", int'(direction_command), 0);

      // Reset pulse while searching (or stopped by loss)
      sensor = 8'b00000110;
      push(2'd1, 1'b0);
      ticks(4);
      sensor = 8'd0;
`ifndef LINE_SEARCH_EN
      push(2'd3, 1'b1);
`endif
      ticks(5);
      check("pre_reset_lost", int'(line_lost), 1);
      #3;
      reset_n = 1'b0;
      #1;
      check("midreset_dir", int'(direction_command), 3);
      check("midreset_valid", int'(cmd_valid), 0);
      check("midreset_lost", int'(line_lost), 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("post_release_dir", int'(direction_command), 3);
      check("post_release_valid", int'(cmd_valid), 0);
      check("sb_drained", q_exp.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
